// File: rtl/pong_pkg.sv
// Shared types, constants and helpers for the pong match controller.
package pong_pkg;

    localparam int unsigned XY_W      = 10;
    localparam int unsigned BTN_W     = 4;
    localparam int unsigned SCORE_W   = 8;
    localparam int unsigned BIN_W     = 7;
    localparam int unsigned TIMER_W   = 7;
    localparam int unsigned REFRESH_Y = 481;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'b00,
        ST_PLAY    = 2'b01,
        ST_NEWBALL = 2'b10,
        ST_OVER    = 2'b11
    } state_t;

    // Two-digit BCD score to binary (00..99 -> 0..99).
    function automatic logic [BIN_W-1:0] bcd2bin(input logic [SCORE_W-1:0] bcd);
        return BIN_W'(bcd[7:4]) * BIN_W'(10) + BIN_W'(bcd[3:0]);
    endfunction

endpackage

// File: rtl/bcd_cnt2.sv
// Two-digit BCD score counter, saturating at 99, with synchronous clear.
module bcd_cnt2
    import pong_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] q,
    output logic [SCORE_W-1:0] q_inc_c
);

    // Value the counter would take on an increment (used for the win look-ahead).
    always_comb begin
        q_inc_c = q;
        if (q != 8'h99) begin
            if (q[3:0] == 4'd9) begin
                q_inc_c = {q[7:4] + 4'd1, 4'd0};
            end else begin
                q_inc_c = {q[7:4], q[3:0] + 4'd1};
            end
        end
    end

    // Score register: clear wins over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= q_inc_c;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Match-level pong controller: game FSM, serve pause timer, button edge detect
// and per-player BCD scores. Define PONG_DEUCE_EN to require a two-point lead.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE   = 11,
    parameter int unsigned PAUSE_TICKS = 120
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [XY_W-1:0]    x,
    input  logic [XY_W-1:0]    y,
    input  logic [BTN_W-1:0]   btn,
    input  logic               pts_1,
    input  logic               pts_2,
    output logic               gra_still,
    output logic [SCORE_W-1:0] sc1_bcd,
    output logic [SCORE_W-1:0] sc2_bcd,
    output logic [1:0]         state,
    output logic               winner
);

    state_t               state_r, state_nxt;
    logic [TIMER_W-1:0]   timer, timer_nxt;
    logic                 winner_nxt;
    logic                 btn_d;
    logic                 tick_c, press_c;
    logic                 clr_c, inc1_c, inc2_c;
    logic                 win1_c, win2_c;
    logic [SCORE_W-1:0]   sc1_inc_c, sc2_inc_c;
    logic [BIN_W-1:0]     bin1_inc_c, bin2_inc_c, bin1_c, bin2_c;

    assign tick_c  = (y == XY_W'(REFRESH_Y)) && (x == '0);
    assign press_c = (|btn) & ~btn_d;
    assign state   = state_r;

    bcd_cnt2 u_sc1 (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_c),
        .inc     (inc1_c),
        .q       (sc1_bcd),
        .q_inc_c (sc1_inc_c)
    );

    bcd_cnt2 u_sc2 (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr_c),
        .inc     (inc2_c),
        .q       (sc2_bcd),
        .q_inc_c (sc2_inc_c)
    );

    // Win look-ahead on the post-increment score.
    always_comb begin
        bin1_inc_c = bcd2bin(sc1_inc_c);
        bin2_inc_c = bcd2bin(sc2_inc_c);
        bin1_c     = bcd2bin(sc1_bcd);
        bin2_c     = bcd2bin(sc2_bcd);
`ifdef PONG_DEUCE_EN
        win1_c = (bin1_inc_c >= BIN_W'(WIN_SCORE)) && (bin1_inc_c >= bin2_c + BIN_W'(2));
        win2_c = (bin2_inc_c >= BIN_W'(WIN_SCORE)) && (bin2_inc_c >= bin1_c + BIN_W'(2));
`else
        win1_c = (bin1_inc_c == BIN_W'(WIN_SCORE));
        win2_c = (bin2_inc_c == BIN_W'(WIN_SCORE));
`endif
    end

    // Next-state, timer, winner and score-control decode.
    always_comb begin
        state_nxt  = state_r;
        timer_nxt  = timer;
        winner_nxt = winner;
        clr_c      = 1'b0;
        inc1_c     = 1'b0;
        inc2_c     = 1'b0;
        case (state_r)
            ST_NEWGAME: begin
                if (press_c) state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (pts_1) begin
                    inc1_c    = 1'b1;
                    timer_nxt = TIMER_W'(PAUSE_TICKS);
                    if (win1_c) begin
                        state_nxt  = ST_OVER;
                        winner_nxt = 1'b0;
                    end else begin
                        state_nxt  = ST_NEWBALL;
                    end
                end else if (pts_2) begin
                    inc2_c    = 1'b1;
                    timer_nxt = TIMER_W'(PAUSE_TICKS);
                    if (win2_c) begin
                        state_nxt  = ST_OVER;
                        winner_nxt = 1'b1;
                    end else begin
                        state_nxt  = ST_NEWBALL;
                    end
                end
            end
            ST_NEWBALL: begin
                if (timer == '0) begin
                    if (press_c) state_nxt = ST_PLAY;
                end else if (tick_c) begin
                    timer_nxt = timer - TIMER_W'(1);
                end
            end
            ST_OVER: begin
                if (timer == '0) begin
                    state_nxt = ST_NEWGAME;
                    clr_c     = 1'b1;
                end else if (tick_c) begin
                    timer_nxt = timer - TIMER_W'(1);
                end
            end
            default: state_nxt = ST_NEWGAME;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_NEWGAME;
            gra_still <= 1'b1;
            winner    <= 1'b0;
            timer     <= '0;
            btn_d     <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            gra_still <= (state_nxt != ST_PLAY);
            winner    <= winner_nxt;
            timer     <= timer_nxt;
            btn_d     <= |btn;
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed scenarios plus randomized
// play against an integer-score reference model. Honours PONG_DEUCE_EN.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x, y;
    logic [3:0] btn;
    logic       pts_1, pts_2;
    logic       gra_still;
    logic [7:0] sc1_bcd, sc2_bcd;
    logic [1:0] state;
    logic       winner;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: game phase 0..3, binary scores, pause counter.
    int m_phase, m_s1, m_s2, m_timer;
    bit m_btn_prev, m_winner;

    pong_game_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .btn       (btn),
        .pts_1     (pts_1),
        .pts_2     (pts_2),
        .gra_still (gra_still),
        .sc1_bcd   (sc1_bcd),
        .sc2_bcd   (sc2_bcd),
        .state     (state),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int s);
        return 8'((s / 10) * 16 + (s % 10));
    endfunction

    function automatic bit wins(input int mine, input int other);
`ifdef PONG_DEUCE_EN
        return (mine >= 11) && (mine - other >= 2);
`else
        return mine == 11;
`endif
    endfunction

    task automatic model_update();
        bit press, tick, won;
        if (reset) begin
            m_phase = 0; m_s1 = 0; m_s2 = 0; m_timer = 0;
            m_btn_prev = 0; m_winner = 0;
        end else begin
            press = (btn != 0) && !m_btn_prev;
            tick  = (y == 10'd481) && (x == 10'd0);
            won   = 0;
            case (m_phase)
                0: if (press) m_phase = 1;
                1: if (pts_1 || pts_2) begin
                    if (pts_1) begin
                        m_s1 = (m_s1 < 99) ? m_s1 + 1 : 99;
                        won = wins(m_s1, m_s2);
                        if (won) m_winner = 0;
                    end else begin
                        m_s2 = (m_s2 < 99) ? m_s2 + 1 : 99;
                        won = wins(m_s2, m_s1);
                        if (won) m_winner = 1;
                    end
                    m_timer = 120;
                    m_phase = won ? 3 : 2;
                end
                2: if (m_timer == 0) begin
                    if (press) m_phase = 1;
                end else if (tick) m_timer--;
                default: if (m_timer == 0) begin
                    m_phase = 0; m_s1 = 0; m_s2 = 0;
                end else if (tick) m_timer--;
            endcase
            m_btn_prev = (btn != 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        btn = 4'd0; pts_1 = 1'b0; pts_2 = 1'b0; x = 10'd5; y = 10'd5;
    endtask

    task automatic wait_ticks(input int n);
        x = 10'd0; y = 10'd481;
        repeat (n) step();
        x = 10'd5; y = 10'd5;
    endtask

    task automatic press_btn();
        btn = 4'b0001; step();
        btn = 4'b0000; step();
    endtask

    task automatic serve(input int p);
        if (p == 1) pts_1 = 1'b1; else pts_2 = 1'b1;
        step();
        pts_1 = 1'b0; pts_2 = 1'b0;
    endtask

    task automatic resume();
        wait_ticks(120);
        press_btn();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1; step(); step();
        reset = 1'b0;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state); end
        n_checks++; if (gra_still !== 1'b1) begin n_fail++; $display("FAIL reset_still got %b exp 1", gra_still); end
        n_checks++; if (sc1_bcd !== 8'h00 || sc2_bcd !== 8'h00) begin n_fail++; $display("FAIL reset_scores got %h/%h exp 00/00", sc1_bcd, sc2_bcd); end
        n_checks++; if (winner !== 1'b0) begin n_fail++; $display("FAIL reset_winner got %b exp 0", winner); end
    endtask

    task automatic test_start();
        btn = 4'b0001; step();
        n_checks++; if (state !== 2'd1 || gra_still !== 1'b0) begin n_fail++; $display("FAIL start_play got state=%0d still=%b exp 1/0", state, gra_still); end
        btn = 4'b0000; step();
    endtask

    task automatic test_point_hold();
        pts_1 = 1'b1;
        repeat (5) step();
        pts_1 = 1'b0;
        n_checks++; if (sc1_bcd !== 8'h01 || sc2_bcd !== 8'h00) begin n_fail++; $display("FAIL hold_once got %h/%h exp 01/00", sc1_bcd, sc2_bcd); end
        n_checks++; if (state !== 2'd2 || gra_still !== 1'b1) begin n_fail++; $display("FAIL hold_newball got state=%0d still=%b exp 2/1", state, gra_still); end
    endtask

    task automatic test_newball_timer();
        wait_ticks(119);
        press_btn();
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL early_press got state=%0d exp 2", state); end
        wait_ticks(1);
        btn = 4'b0001; step();
        n_checks++; if (state !== 2'd1 || gra_still !== 1'b0) begin n_fail++; $display("FAIL late_press got state=%0d still=%b exp 1/0", state, gra_still); end
        btn = 4'b0000; step();
    endtask

    task automatic test_bcd_carry();
        repeat (7) begin serve(1); resume(); end
        pts_1 = 1'b1; pts_2 = 1'b1; step();
        pts_1 = 1'b0; pts_2 = 1'b0;
        n_checks++; if (sc1_bcd !== 8'h09 || sc2_bcd !== 8'h00) begin n_fail++; $display("FAIL both_pts got %h/%h exp 09/00", sc1_bcd, sc2_bcd); end
        resume();
        serve(1);
        n_checks++; if (sc1_bcd !== 8'h10 || state !== 2'd2) begin n_fail++; $display("FAIL bcd_carry got sc1=%h state=%0d exp 10/2", sc1_bcd, state); end
        resume();
    endtask

    task automatic test_win();
        serve(1);
        n_checks++; if (state !== 2'd3 || winner !== 1'b0 || gra_still !== 1'b1) begin n_fail++; $display("FAIL win_over got state=%0d winner=%b still=%b exp 3/0/1", state, winner, gra_still); end
        n_checks++; if (sc1_bcd !== 8'h11) begin n_fail++; $display("FAIL win_score got %h exp 11", sc1_bcd); end
        btn = 4'b0001;
        wait_ticks(120);
        btn = 4'b0000;
        n_checks++; if (state !== 2'd3) begin n_fail++; $display("FAIL over_hold got state=%0d exp 3", state); end
        step();
        n_checks++; if (state !== 2'd0 || sc1_bcd !== 8'h00 || sc2_bcd !== 8'h00) begin n_fail++; $display("FAIL over_to_new got state=%0d sc=%h/%h exp 0 00/00", state, sc1_bcd, sc2_bcd); end
        press_btn();
        n_checks++; if (state !== 2'd1 || sc1_bcd !== 8'h00) begin n_fail++; $display("FAIL new_press got state=%0d sc1=%h exp 1/00", state, sc1_bcd); end
    endtask

    task automatic test_deuce();
        repeat (10) begin serve(1); resume(); serve(2); resume(); end
        n_checks++; if (sc1_bcd !== 8'h10 || sc2_bcd !== 8'h10 || state !== 2'd1) begin n_fail++; $display("FAIL ten_all got %h/%h state=%0d exp 10/10 1", sc1_bcd, sc2_bcd, state); end
        serve(1);
        n_checks++; if (sc1_bcd !== 8'h11 || sc2_bcd !== 8'h10) begin n_fail++; $display("FAIL eleven_ten got %h/%h exp 11/10", sc1_bcd, sc2_bcd); end
`ifdef PONG_DEUCE_EN
        n_checks++; if (state !== 2'd2) begin n_fail++; $display("FAIL deuce_nowin got state=%0d exp 2", state); end
        resume();
        serve(1);
        n_checks++; if (state !== 2'd3 || winner !== 1'b0 || sc1_bcd !== 8'h12) begin n_fail++; $display("FAIL deuce_win got state=%0d winner=%b sc1=%h exp 3/0/12", state, winner, sc1_bcd); end
`else
        n_checks++; if (state !== 2'd3 || winner !== 1'b0) begin n_fail++; $display("FAIL plain_win got state=%0d winner=%b exp 3/0", state, winner); end
`endif
        wait_ticks(120);
        step();
        press_btn();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL deuce_restart got state=%0d exp 1", state); end
    endtask

    task automatic test_reset_mid();
        serve(2);
        n_checks++; if (sc2_bcd !== 8'h01 || state !== 2'd2) begin n_fail++; $display("FAIL p2_point got sc2=%h state=%0d exp 01/2", sc2_bcd, state); end
        resume();
        reset = 1'b1; step(); reset = 1'b0;
        n_checks++; if (state !== 2'd0 || gra_still !== 1'b1 || sc1_bcd !== 8'h00 || sc2_bcd !== 8'h00) begin n_fail++; $display("FAIL mid_reset got state=%0d still=%b sc=%h/%h exp 0/1 00/00", state, gra_still, sc1_bcd, sc2_bcd); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8000; i++) begin
            reset = ($urandom_range(0, 1999) == 0);
            btn   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            pts_1 = ($urandom_range(0, 7) == 0);
            pts_2 = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) != 0) begin
                x = 10'd0; y = 10'd481;
            end else begin
                x = 10'($urandom); y = 10'($urandom);
            end
            step();
            n_checks++; if (state !== 2'(m_phase)) begin n_fail++; $display("FAIL rnd_state cyc=%0d got %0d exp %0d", i, state, m_phase); end
            n_checks++; if (gra_still !== (m_phase != 1)) begin n_fail++; $display("FAIL rnd_still cyc=%0d got %b exp %b", i, gra_still, (m_phase != 1)); end
            n_checks++; if (sc1_bcd !== to_bcd(m_s1) || sc2_bcd !== to_bcd(m_s2)) begin n_fail++; $display("FAIL rnd_score cyc=%0d got %h/%h exp %h/%h", i, sc1_bcd, sc2_bcd, to_bcd(m_s1), to_bcd(m_s2)); end
            if (m_phase == 3) begin
                n_checks++; if (winner !== m_winner) begin n_fail++; $display("FAIL rnd_winner cyc=%0d got %b exp %b", i, winner, m_winner); end
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_start();
        test_point_hold();
        test_newball_timer();
        test_bcd_carry();
        test_win();
        test_deuce();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
